// File: rtl/fb_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fb_arbiter
//
// Shares one single-port, synchronous-read frame-buffer RAM between the
// display scan-out and a pixel writer.  During the active picture the
// even-X cycle of every column pair is a READ slot; the odd-X cycle and all
// blanking cycles are WRITE slots.  Each displayed word feeds two adjacent
// columns and two adjacent rows, so the read stream needs only half of the
// RAM bandwidth.
//
// Writer requests queue in a small FIFO and drain one entry per WRITE slot.
// Scan-out reads are never delayed by queued writes.
//
// Ports
//   CLK, RST_n          pixel clock, asynchronous active-low reset
//   col, fil, DEN       sync-generator column, row and data enable
//   wr_valid/wr_ready   writer handshake, with wr_addr / wr_data (RGB565)
//   mem_addr/mem_wdata  RAM address and write data
//   mem_we              RAM write strobe
//   mem_rdata           RAM read data, valid one cycle after the address
//   R, G, B             8-bit colour channels, zero outside the picture
//   den_o               DEN delayed to line up with R/G/B
//   fifo_lvl            write FIFO occupancy, 0..FIFO_D
// ---------------------------------------------------------------------------
module fb_arbiter #(
   parameter int H_OFF  = 216,
   parameter int V_OFF  = 35,
   parameter int H_ACT  = 800,
   parameter int V_ACT  = 480,
   parameter int AW     = 17,
   parameter int FIFO_D = 4
) (
   input  logic          CLK,
   input  logic          RST_n,
   input  logic [10:0]   col,
   input  logic [9:0]    fil,
   input  logic          DEN,
   input  logic          wr_valid,
   input  logic [AW-1:0] wr_addr,
   input  logic [15:0]   wr_data,
   output logic          wr_ready,
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   mem_wdata,
   output logic          mem_we,
   input  logic [15:0]   mem_rdata,
   output logic [7:0]    R,
   output logic [7:0]    G,
   output logic [7:0]    B,
   output logic          den_o,
   output logic [2:0]    fifo_lvl
);

   // FIFO_D is a power of two (>= 2), so pointers wrap on their own.
   localparam int PW = $clog2(FIFO_D);
   localparam int LW = $clog2(FIFO_D + 1);

   // RGB565 channel expansion: zero-fill the low bits.
   function automatic logic [7:0] expand5(input logic [4:0] v);
      return {v, 3'b000};
   endfunction

   function automatic logic [7:0] expand6(input logic [5:0] v);
      return {v, 2'b00};
   endfunction

   // Blank a channel outside the displayed area.
   function automatic logic [7:0] blank(input logic en, input logic [7:0] v);
      return en ? v : 8'd0;
   endfunction

   // ------------------------------------------------------------------
   // Stage p0: slot decode and RAM request (combinational)
   // ------------------------------------------------------------------
   logic [10:0]   x_p0;
   logic [9:0]    y_p0;
   logic          active_p0;
   logic          rd_slot_p0;
   logic [AW-1:0] rd_addr_p0;

   // Offsets subtract modulo the counter width, so pre-picture columns
   // and rows wrap to large values and fall outside the active window.
   assign x_p0      = col - 11'(H_OFF);
   assign y_p0      = fil - 10'(V_OFF);
   assign active_p0 = DEN && (x_p0 < 11'(H_ACT)) && (y_p0 < 10'(V_ACT));
   assign rd_slot_p0 = active_p0 && !x_p0[0];

   // One word per 2x2 screen block; line stride in RAM is 512 words.
   assign rd_addr_p0 = AW'({y_p0[9:1], 9'd0}) + AW'(x_p0[10:1]);

   // Write FIFO state
   logic [AW-1:0] fifo_addr [FIFO_D];
   logic [15:0]   fifo_data [FIFO_D];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [LW-1:0] lvl;
   logic          rdy_en;
   logic [AW-1:0] last_raddr;
   logic          push;
   logic          pop;

   // rdy_en keeps wr_ready low during reset and releases it on the first
   // clock edge afterwards.  Readiness depends on the registered level
   // only, so a pop in the current cycle does not open the FIFO until
   // the next one.
   assign wr_ready = rdy_en && (lvl < LW'(FIFO_D));
   assign push     = wr_valid && wr_ready;
   assign pop      = !rd_slot_p0 && (lvl != '0);

   // An idle WRITE slot parks the address on the last read so the RAM
   // address bus does not toggle needlessly.
   always_comb begin
      mem_addr  = last_raddr;
      mem_we    = 1'b0;
      mem_wdata = fifo_data[rptr];
      if (rd_slot_p0) begin
         mem_addr = rd_addr_p0;
      end else if (pop) begin
         mem_addr = fifo_addr[rptr];
         mem_we   = 1'b1;
      end
   end

   // FIFO storage is data only and needs no reset; occupancy is tracked
   // by the control registers below.
   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_addr[wptr] <= wr_addr;
         fifo_data[wptr] <= wr_data;
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         wptr       <= '0;
         rptr       <= '0;
         lvl        <= '0;
         rdy_en     <= 1'b0;
         last_raddr <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   lvl <= lvl + 1'b1;
            2'b01:   lvl <= lvl - 1'b1;
            default: lvl <= lvl;
         endcase
         if (rd_slot_p0) last_raddr <= rd_addr_p0;
      end
   end

   assign fifo_lvl = 3'(lvl);

   // ------------------------------------------------------------------
   // Stage p1: RAM data returns for the previous cycle's READ slot
   // ------------------------------------------------------------------
   logic rd_vld_p1;
   logic den_p1;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         rd_vld_p1 <= 1'b0;
         den_p1    <= 1'b0;
      end else begin
         rd_vld_p1 <= rd_slot_p0;
         den_p1    <= DEN;
      end
   end

   // ------------------------------------------------------------------
   // Stage p2: pixel register and colour output
   // ------------------------------------------------------------------
   logic [15:0] pix_p2;
   logic        vld_p2;

   // Only read data is captured; the word fetched for an even column is
   // held across the following WRITE slot so both columns show it.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         pix_p2 <= '0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p2 <= den_p1;
         if (rd_vld_p1) pix_p2 <= mem_rdata;
      end
   end

   assign den_o = vld_p2;
   assign R     = blank(vld_p2, expand5(pix_p2[15:11]));
   assign G     = blank(vld_p2, expand6(pix_p2[10:5]));
   assign B     = blank(vld_p2, expand5(pix_p2[4:0]));

endmodule

// File: tb/tb_fb_arbiter.sv
`timescale 1ns/1ps
// Directed testbench for fb_arbiter.  A behavioural synchronous-read RAM
// hangs off the memory port; every expected value below is written out by
// hand from the intended behaviour.
module tb_fb_arbiter;

   localparam int AW = 17;

   logic          CLK = 1'b0;
   logic          RST_n;
   logic [10:0]   col;
   logic [9:0]    fil;
   logic          DEN;
   logic          wr_valid;
   logic [AW-1:0] wr_addr;
   logic [15:0]   wr_data;
   logic          wr_ready;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_wdata;
   logic          mem_we;
   logic [15:0]   mem_rdata;
   logic [7:0]    R, G, B;
   logic          den_o;
   logic [2:0]    fifo_lvl;

   int errors = 0;
   int checks = 0;

   // Image words written in test_blank_writes at addresses 0..3 and the
   // colours they must produce.
   logic [15:0] img     [4] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
   logic [23:0] exp_rgb [4] = '{24'hF80000, 24'h00FC00, 24'h0000F8, 24'hF8FCF8};

   fb_arbiter #(
      .H_OFF(216), .V_OFF(35), .H_ACT(800), .V_ACT(480), .AW(AW), .FIFO_D(4)
   ) dut (
      .CLK(CLK), .RST_n(RST_n),
      .col(col), .fil(fil), .DEN(DEN),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .R(R), .G(G), .B(B), .den_o(den_o), .fifo_lvl(fifo_lvl)
   );

   always #5 CLK = ~CLK;

   // Single-port RAM, read-before-write, one cycle read latency.
   logic [15:0] mem [0:(1<<AW)-1];
   always @(posedge CLK) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   task automatic drive(input logic den, input int c, input int f,
                        input logic wv, input int wa, input int wd);
      DEN      = den;
      col      = 11'(c);
      fil      = 10'(f);
      wr_valid = wv;
      wr_addr  = AW'(wa);
      wr_data  = 16'(wd);
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST_n = 1'b0;
      drive(1'b0, 0, 0, 1'b0, 0, 0);
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if ({fifo_lvl, wr_ready, mem_we, den_o, R, G, B} !== {3'd0, 1'b0, 1'b0, 1'b0, 24'd0}) begin
         errors++;
         $display("FAIL reset_state: lvl=%0d rdy=%b we=%b den_o=%b rgb=%h required 0,0,0,0,000000",
                  fifo_lvl, wr_ready, mem_we, den_o, {R, G, B});
      end
      RST_n = 1'b1;
      @(negedge CLK);
      checks++;
      if (wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_before_edge: wr_ready=%b required 0", wr_ready);
      end
      next_cycle();
      checks++;
      if ({wr_ready, fifo_lvl} !== {1'b1, 3'd0}) begin
         errors++;
         $display("FAIL ready_after_edge: wr_ready=%b lvl=%0d required 1,0", wr_ready, fifo_lvl);
      end
   endtask

   // Blanking: four back-to-back pushes drain one per cycle, in order.
   task automatic test_blank_writes();
      for (int c = 0; c < 6; c++) begin
         if (c < 4) drive(1'b0, 0, 0, 1'b1, c, int'(img[c]));
         else       drive(1'b0, 0, 0, 1'b0, 0, 0);
         @(negedge CLK);
         if (c == 0) begin
            checks++;
            if ({wr_ready, mem_we, mem_addr} !== {1'b1, 1'b0, 17'd0}) begin
               errors++;
               $display("FAIL blank_idle: rdy=%b we=%b addr=%h required 1,0,00000",
                        wr_ready, mem_we, mem_addr);
            end
         end else if (c <= 4) begin
            checks++;
            if ({mem_we, mem_addr, mem_wdata, fifo_lvl} !== {1'b1, AW'(c - 1), img[c-1], 3'd1}) begin
               errors++;
               $display("FAIL blank_write%0d: we=%b addr=%h data=%h lvl=%0d required 1,%h,%h,1",
                        c - 1, mem_we, mem_addr, mem_wdata, fifo_lvl, c - 1, img[c-1]);
            end
         end else begin
            checks++;
            if ({mem_we, fifo_lvl} !== {1'b0, 3'd0}) begin
               errors++;
               $display("FAIL blank_drained: we=%b lvl=%0d required 0,0", mem_we, fifo_lvl);
            end
         end
         next_cycle();
      end
   endtask

   // Holding col=216 makes every cycle a READ slot, so the FIFO can be
   // preloaded; then one line segment is swept.
   task automatic test_active_line();
      for (int p = 0; p < 4; p++) begin
         drive(1'b1, 216, 35, 1'b1, 'h400 + p, 'hA000 + p);
         @(negedge CLK);
         checks++;
         if ({wr_ready, mem_we, mem_addr} !== {1'b1, 1'b0, 17'd0}) begin
            errors++;
            $display("FAIL preload%0d: rdy=%b we=%b addr=%h required 1,0,00000",
                     p, wr_ready, mem_we, mem_addr);
         end
         next_cycle();
      end
      for (int s = 0; s < 12; s++) begin
         if (s < 8) drive(1'b1, 216 + s, 35, 1'b0, 0, 0);
         else       drive(1'b0, 0, 0, 1'b0, 0, 0);
         @(negedge CLK);
         checks++;
         if (s < 8 && s % 2 == 0) begin
            if ({mem_we, mem_addr} !== {1'b0, AW'(s / 2)}) begin
               errors++;
               $display("FAIL line_read col%0d: we=%b addr=%h required 0,%h", 216 + s, mem_we, mem_addr, s / 2);
            end
         end else if (s < 8) begin
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, AW'('h400 + (s - 1) / 2), 16'('hA000 + (s - 1) / 2)}) begin
               errors++;
               $display("FAIL line_write col%0d: we=%b addr=%h data=%h required 1,%h,%h",
                        216 + s, mem_we, mem_addr, mem_wdata, 'h400 + (s - 1) / 2, 'hA000 + (s - 1) / 2);
            end
         end else begin
            if ({mem_we, mem_addr} !== {1'b0, 17'd3}) begin
               errors++;
               $display("FAIL line_hold s%0d: we=%b addr=%h required 0,00003", s, mem_we, mem_addr);
            end
         end
         checks++;
         if (s < 10) begin
            if ({den_o, R, G, B} !== {1'b1, exp_rgb[(s < 2) ? 0 : (s - 2) / 2]}) begin
               errors++;
               $display("FAIL pixel s%0d: den_o=%b rgb=%h required 1,%h",
                        s, den_o, {R, G, B}, exp_rgb[(s < 2) ? 0 : (s - 2) / 2]);
            end
         end else begin
            if ({den_o, R, G, B} !== 25'd0) begin
               errors++;
               $display("FAIL pixel_blank s%0d: den_o=%b rgb=%h required 0,000000", s, den_o, {R, G, B});
            end
         end
         next_cycle();
      end
      checks++;
      if (fifo_lvl !== 3'd0) begin
         errors++;
         $display("FAIL line_empty: lvl=%0d required 0", fifo_lvl);
      end
   endtask

   // Full FIFO with wr_valid held: nothing lost, push resumes after a pop.
   task automatic test_backpressure();
      logic [AW-1:0] dr_a [3] = '{17'h502, 17'h503, 17'h5FF};
      logic [15:0]   dr_d [3] = '{16'hB002, 16'hB003, 16'hBEEF};
      for (int p = 0; p < 4; p++) begin
         drive(1'b1, 216, 35, 1'b1, 'h500 + p, 'hB000 + p);
         next_cycle();
      end
      for (int f = 0; f < 2; f++) begin
         drive(1'b1, 216, 35, 1'b1, 'h5FF, 'hBEEF);
         @(negedge CLK);
         checks++;
         if ({wr_ready, fifo_lvl, mem_we} !== {1'b0, 3'd4, 1'b0}) begin
            errors++;
            $display("FAIL full_hold%0d: rdy=%b lvl=%0d we=%b required 0,4,0", f, wr_ready, fifo_lvl, mem_we);
         end
         next_cycle();
      end
      drive(1'b1, 217, 35, 1'b1, 'h5FF, 'hBEEF);
      @(negedge CLK);
      checks++;
      if ({wr_ready, fifo_lvl, mem_we, mem_addr, mem_wdata} !== {1'b0, 3'd4, 1'b1, 17'h500, 16'hB000}) begin
         errors++;
         $display("FAIL full_pop: rdy=%b lvl=%0d we=%b addr=%h data=%h required 0,4,1,00500,b000",
                  wr_ready, fifo_lvl, mem_we, mem_addr, mem_wdata);
      end
      next_cycle();
      drive(1'b1, 216, 35, 1'b1, 'h5FF, 'hBEEF);
      @(negedge CLK);
      checks++;
      if ({wr_ready, fifo_lvl, mem_we} !== {1'b1, 3'd3, 1'b0}) begin
         errors++;
         $display("FAIL reopen: rdy=%b lvl=%0d we=%b required 1,3,0", wr_ready, fifo_lvl, mem_we);
      end
      next_cycle();
      drive(1'b1, 217, 35, 1'b0, 0, 0);
      @(negedge CLK);
      checks++;
      if ({fifo_lvl, mem_we, mem_addr, mem_wdata} !== {3'd4, 1'b1, 17'h501, 16'hB001}) begin
         errors++;
         $display("FAIL refill_pop: lvl=%0d we=%b addr=%h data=%h required 4,1,00501,b001",
                  fifo_lvl, mem_we, mem_addr, mem_wdata);
      end
      next_cycle();
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 0, 0, 1'b0, 0, 0);
         @(negedge CLK);
         checks++;
         if (k < 3) begin
            if ({fifo_lvl, mem_we, mem_addr, mem_wdata} !== {3'(3 - k), 1'b1, dr_a[k], dr_d[k]}) begin
               errors++;
               $display("FAIL drain%0d: lvl=%0d we=%b addr=%h data=%h required %0d,1,%h,%h",
                        k, fifo_lvl, mem_we, mem_addr, mem_wdata, 3 - k, dr_a[k], dr_d[k]);
            end
         end else begin
            if ({fifo_lvl, mem_we} !== {3'd0, 1'b0}) begin
               errors++;
               $display("FAIL drain_end: lvl=%0d we=%b required 0,0", fifo_lvl, mem_we);
            end
         end
         next_cycle();
      end
   endtask

   // Row pairs share a RAM line; the next pair starts 512 words on.
   task automatic test_row_addr();
      for (int r = 36; r <= 37; r++) begin
         for (int k = 0; k < 4; k++) begin
            drive(1'b1, 216 + k, r, 1'b0, 0, 0);
            @(negedge CLK);
            checks++;
            if (k % 2 == 0) begin
               if ({mem_we, mem_addr} !== {1'b0, AW'(((r == 37) ? 512 : 0) + k / 2)}) begin
                  errors++;
                  $display("FAIL row%0d_col%0d: we=%b addr=%h required 0,%h",
                           r, 216 + k, mem_we, mem_addr, ((r == 37) ? 512 : 0) + k / 2);
               end
            end else begin
               if (mem_we !== 1'b0) begin
                  errors++;
                  $display("FAIL row%0d_idle%0d: we=%b required 0", r, 216 + k, mem_we);
               end
            end
            next_cycle();
         end
      end
      drive(1'b0, 0, 0, 1'b0, 0, 0);
      next_cycle();
   endtask

   // Reset mid-line with queued writes: immediate clear, nothing replayed.
   task automatic test_reset_midline();
      for (int p = 0; p < 3; p++) begin
         drive(1'b1, 216, 35, 1'b1, 'h600 + p, 'hC000 + p);
         next_cycle();
      end
      drive(1'b1, 216, 35, 1'b0, 0, 0);
      @(negedge CLK);
      checks++;
      if ({fifo_lvl, den_o, R, G, B} !== {3'd3, 1'b1, 24'hF80000}) begin
         errors++;
         $display("FAIL pre_reset: lvl=%0d den_o=%b rgb=%h required 3,1,f80000", fifo_lvl, den_o, {R, G, B});
      end
      next_cycle();
      drive(1'b1, 217, 35, 1'b0, 0, 0);
      #1;
      checks++;
      if ({mem_we, mem_addr} !== {1'b1, 17'h600}) begin
         errors++;
         $display("FAIL pre_reset_we: we=%b addr=%h required 1,00600", mem_we, mem_addr);
      end
      RST_n = 1'b0;
      #1;
      checks++;
      if ({fifo_lvl, mem_we, wr_ready, den_o, R, G, B} !== {3'd0, 1'b0, 1'b0, 1'b0, 24'd0}) begin
         errors++;
         $display("FAIL async_reset: lvl=%0d we=%b rdy=%b den_o=%b rgb=%h required 0,0,0,0,000000",
                  fifo_lvl, mem_we, wr_ready, den_o, {R, G, B});
      end
      repeat (2) @(posedge CLK);
      #1;
      RST_n = 1'b1;
      drive(1'b0, 0, 0, 1'b0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         checks++;
         if ({mem_we, fifo_lvl} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL post_reset%0d: we=%b lvl=%0d required 0,0", k, mem_we, fifo_lvl);
         end
         next_cycle();
      end
   endtask

   initial begin
      test_reset();
      test_blank_writes();
      test_active_line();
      test_backpressure();
      test_row_addr();
      test_reset_midline();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): H_OFF 216, first active column; V_OFF 35, first active row; H_ACT 800, active width; V_ACT 480, active height; AW 17, memory address width; FIFO_D 4, write FIFO depth (power of 2).
REQ-002 Ports SHALL be (name direction width meaning): CLK in 1 pixel clock; RST_n in 1 asynchronous active-low reset; one clock, all logic on CLK rising edge.
REQ-003 col in 11 sync-generator column; fil in 10 sync-generator row; DEN in 1 sync data-enable.
REQ-004 wr_valid in 1 writer request; wr_addr in AW write word address; wr_data in 16 RGB565 write word; wr_ready out 1 FIFO can accept.
REQ-005 mem_addr out AW RAM address; mem_wdata out 16 RAM write data; mem_we out 1 RAM write strobe; mem_rdata in 16 RAM read data (1-cycle synchronous read latency).
REQ-006 R, G, B out 8 each pixel colour; den_o out 1 DEN delayed to align with R/G/B; fifo_lvl out 3 write FIFO occupancy (0..FIFO_D).

Function
REQ-007 X SHALL be col-H_OFF (11 bits), Y SHALL be fil-V_OFF (10 bits), modulo width.
REQ-008 Active SHALL mean DEN=1 and X<H_ACT and Y<V_ACT.
REQ-009 Read address SHALL be Y[9:1]*512 + X[10:1], truncated to AW bits (2x pixel replication, stride 512).
REQ-010 Slot decode per cycle: active and X[0]=0 -> READ slot; active and X[0]=1, or not active -> WRITE slot.
REQ-011 READ slot: mem_addr=read address, mem_we=0; READ always wins, never stalled by writes.
REQ-012 WRITE slot with FIFO non-empty: pop head, mem_addr/mem_wdata=head entry, mem_we=1, exactly one write per slot.
REQ-013 WRITE slot with FIFO empty: mem_we=0, mem_addr=last read address held.
REQ-014 mem_addr, mem_wdata, mem_we SHALL be combinational from slot decode and FIFO head (no added latency).
REQ-015 Write handshake: entry accepted on CLK edge where wr_valid=1 and wr_ready=1; wr_ready=1 iff fifo_lvl<FIFO_D (registered-level based, not combinational from pop).
REQ-016 Push and pop in same cycle SHALL both occur; level unchanged; pushed entry not poppable before next cycle.
REQ-017 FIFO order SHALL be strict first-in first-out; pointers wrap modulo FIFO_D; no overflow or underflow possible.
REQ-018 Pixel pipeline: cycle n READ slot issues address; cycle n+1 mem_rdata captured into pixel register; pixel register held through following WRITE slot.
REQ-019 R={pix[15:11],3'b000}, G={pix[10:5],2'b00}, B={pix[4:0],3'b000}, from pixel register.
REQ-020 den_o SHALL be DEN delayed 2 cycles; R/G/B SHALL be forced to 0 when den_o=0.
REQ-021 Display latency: column c at cycle n appears on R/G/B at cycle n+2; columns 2k and 2k+1 show identical colour.
REQ-022 Write addresses SHALL be passed through unchecked; an address equal to one being read in the same line is written in its own slot, ordering vs reads by slot time only.

Reset
REQ-023 RST_n=0 SHALL asynchronously clear FIFO pointers, fifo_lvl=0, pixel register=0, den_o pipeline=0, R=G=B=0.
REQ-024 During reset wr_ready=0, mem_we=0; wr_ready rises first CLK edge after RST_n deasserts.
REQ-025 Reset mid-operation SHALL discard all queued writes; no partial write issued after reset.

Verification
REQ-026 Reset then idle blanking (DEN=0): push 4 writes A0..A3 back-to-back -> each written on consecutive cycles, mem_we 1 cycle each, order A0..A3, fifo_lvl returns to 0.
REQ-027 Active line, FIFO preloaded with 4 entries, col=216..223, fil=35 -> mem_we only at col 217,219,221,223; reads at 216,218,220,222 with addresses 0,1,2,3.
REQ-028 mem_rdata=16'hF800 at read of X=0 -> R=8'hF8, G=0, B=0, den_o=1 for X=0 and X=1 pixels, 2 cycles after col.
REQ-029 Writer holds wr_valid=1 during active with FIFO full -> wr_ready=0, no entry lost; push accepted the edge after a pop lowers level to 3.
REQ-030 Assert RST_n=0 with 3 queued writes mid-line -> fifo_lvl=0, R/G/B=0, mem_we=0 immediately; no queued write appears after release.
REQ-031 fil=36 (Y=1) -> same read addresses as Y=0; fil=37 -> addresses offset by 512.
